// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the product accumulator.
// Widths are sized so a full burst of maximum products cannot overflow.
package mult_pkg;

    localparam int PW        = 8;
    localparam int MAX_BEATS = 16;
    localparam int AW        = 12;
    localparam int CW        = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/acc_adder.sv
// AW-bit Kogge-Stone prefix adder built from grey/black cells,
// matching the final adder of the array multiplier.
module acc_adder #(
    parameter int AW = 12
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic [AW-1:0] sum
);

    localparam int L = $clog2(AW);

    logic [AW-1:0] g [0:L];
    logic [AW-1:0] p [0:L];
    logic [AW-1:0] c;

    function automatic logic [1:0] black(
        input logic gh, input logic ph,
        input logic gl, input logic pl
    );
        return {gh | (ph & gl), ph & pl};
    endfunction

    function automatic logic grey(
        input logic gh, input logic ph, input logic gl
    );
        return gh | (ph & gl);
    endfunction

    always_comb begin
        g[0] = a & b;
        p[0] = a ^ b;
        for (int l = 0; l < L; l++) begin
            for (int i = 0; i < AW; i++) begin
                int d;
                int j;
                d = 1 << l;
                j = (i >= d) ? i - d : i;
                g[l+1][i] = g[l][i];
                p[l+1][i] = p[l][i];
                if (i >= d) begin
                    // Bits whose span already reaches bit 0 only need G.
                    if (i < 2 * d) begin
                        g[l+1][i] = grey(g[l][i], p[l][i], g[l][j]);
                    end else begin
                        {g[l+1][i], p[l+1][i]} =
                            black(g[l][i], p[l][i], g[l][j], p[l][j]);
                    end
                end
            end
        end
        c   = {g[L][AW-2:0], 1'b0};
        sum = p[0] ^ c;
    end

endmodule

// File: rtl/mult_prod_accumulator.sv
// Sums bursts of multiplier products and presents each burst total
// on a registered valid/ready output with backpressure.
module mult_prod_accumulator #(
    parameter int PW        = mult_pkg::PW,
    parameter int MAX_BEATS = mult_pkg::MAX_BEATS,
    parameter int AW        = mult_pkg::AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PW-1:0]           in_prod,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AW-1:0]           out_sum,
    output logic [mult_pkg::CW-1:0] out_count,
    output logic                    out_forced
);

    import mult_pkg::*;

    state_e        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] sum_q, sum_d;
    logic [CW-1:0] count_q, count_d;
    logic          forced_q, forced_d;

    logic          fire;
    logic          first;
    logic          close;
    logic [AW-1:0] add_a;
    logic [AW-1:0] add_sum;
    logic [CW-1:0] new_cnt;

    assign in_ready = !valid_q | out_ready;
    assign fire     = in_valid & in_ready;
    assign first    = (state_q != ACC);

    // A fresh burst adds onto zero, so one adder covers both cases.
    assign add_a   = first ? '0 : acc_q;
    assign new_cnt = first ? CW'(1) : cnt_q + CW'(1);
    assign close   = in_last | (new_cnt == CW'(MAX_BEATS));

    acc_adder #(.AW(AW)) u_add (
        .a   (add_a),
        .b   ({{(AW-PW){1'b0}}, in_prod}),
        .sum (add_sum)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        sum_d    = sum_q;
        count_d  = count_q;
        forced_d = forced_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
        end
        if (fire) begin
            acc_d = add_sum;
            cnt_d = new_cnt;
            if (close) begin
                sum_d    = add_sum;
                count_d  = new_cnt;
                forced_d = !in_last;
                valid_d  = 1'b1;
                state_d  = HOLD;
            end else begin
                state_d = ACC;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            sum_q    <= '0;
            count_q  <= '0;
            forced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            sum_q    <= sum_d;
            count_q  <= count_d;
            forced_q <= forced_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_sum    = sum_q;
    assign out_count  = count_q;
    assign out_forced = forced_q;

endmodule

// File: tb/tb_mult_prod_accumulator.sv
// Directed and randomised checks of the product accumulator against
// hand-computed values and a burst-level reference model.
module tb_mult_prod_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_prod;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic [4:0]  out_count;
    logic        out_forced;

    int n_chk  = 0;
    int n_fail = 0;

    int m_acc, m_cnt, e_sum, e_cnt;
    bit m_busy, e_valid, e_forced;

    mult_prod_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_prod    (in_prod),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count),
        .out_forced (out_forced)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_busy = 0;
        e_valid = 0; e_sum = 0; e_cnt = 0; e_forced = 0;
    endtask

    // Advance one clock, updating the reference model from the inputs.
    task automatic tick();
        bit fire;
        fire = in_valid && (!e_valid || out_ready);
        if (e_valid && out_ready) e_valid = 0;
        if (fire) begin
            if (!m_busy) begin
                m_acc = int'(in_prod); m_cnt = 1;
            end else begin
                m_acc += int'(in_prod); m_cnt++;
            end
            if (in_last || m_cnt == 16) begin
                e_valid = 1; e_sum = m_acc; e_cnt = m_cnt;
                e_forced = !in_last; m_busy = 0;
            end else begin
                m_busy = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] p, input logic l);
        in_valid = 1'b1; in_prod = p; in_last = l;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        int drained;
        int cycles;
        rst = 1'b1; in_valid = 0; in_prod = 0; in_last = 0; out_ready = 1;
        model_reset();
        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(out_sum), 0);
        chk("rst_count", 32'(out_count), 0);
        chk("rst_forced", 32'(out_forced), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // 3-beat burst
        beat(8'd15, 0);
        chk("b3_v1", 32'(out_valid), 0);
        beat(8'd225, 0);
        chk("b3_v2", 32'(out_valid), 0);
        beat(8'd6, 1);
        chk("b3_valid", 32'(out_valid), 1);
        chk("b3_sum", 32'(out_sum), 246);
        chk("b3_count", 32'(out_count), 3);
        chk("b3_forced", 32'(out_forced), 0);
        idle();
        chk("b3_drain", 32'(out_valid), 0);

        // 16 beats without last
        for (int i = 0; i < 15; i++) beat(8'd225, 0);
        chk("b16_v15", 32'(out_valid), 0);
        beat(8'd225, 0);
        chk("b16_valid", 32'(out_valid), 1);
        chk("b16_sum", 32'(out_sum), 3600);
        chk("b16_count", 32'(out_count), 16);
        chk("b16_forced", 32'(out_forced), 1);
        beat(8'd7, 0);
        chk("b17_drain", 32'(out_valid), 0);
        beat(8'd1, 1);
        chk("b17_sum", 32'(out_sum), 8);
        chk("b17_count", 32'(out_count), 2);
        chk("b17_forced", 32'(out_forced), 0);
        idle();

        // Backpressure
        out_ready = 0;
        beat(8'd10, 0);
        beat(8'd20, 1);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_sum0", 32'(out_sum), 30);
        in_valid = 1; in_prod = 8'd50; in_last = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_sum", 32'(out_sum), 30);
            chk("bp_count", 32'(out_count), 2);
            chk("bp_hold_valid", 32'(out_valid), 1);
            tick();
        end
        out_ready = 1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 1);
        tick();
        in_valid = 0; in_last = 0;
        chk("bp_next_valid", 32'(out_valid), 1);
        chk("bp_next_sum", 32'(out_sum), 50);
        chk("bp_next_count", 32'(out_count), 1);
        idle();
        chk("bp_drain", 32'(out_valid), 0);

        // Back-to-back single-beat bursts
        beat(8'd9, 1);
        chk("bb_sum9", 32'(out_sum), 9);
        chk("bb_ready9", 32'(in_ready), 1);
        beat(8'd0, 1);
        chk("bb_valid0", 32'(out_valid), 1);
        chk("bb_sum0", 32'(out_sum), 0);
        chk("bb_ready0", 32'(in_ready), 1);
        beat(8'd225, 1);
        chk("bb_sum225", 32'(out_sum), 225);
        chk("bb_count225", 32'(out_count), 1);
        idle();

        // Async reset while holding a result
        out_ready = 0;
        beat(8'd100, 1);
        chk("rh_valid", 32'(out_valid), 1);
        #2 rst = 1;
        #1;
        chk("rh_valid_clr", 32'(out_valid), 0);
        chk("rh_sum_clr", 32'(out_sum), 0);
        chk("rh_count_clr", 32'(out_count), 0);
        #1 rst = 0;
        model_reset();
        out_ready = 1;
        @(posedge clk); #1;

        // Async reset mid-burst
        beat(8'd15, 0);
        beat(8'd15, 0);
        #2 rst = 1;
        #1;
        chk("rm_valid", 32'(out_valid), 0);
        chk("rm_in_ready", 32'(in_ready), 1);
        #1 rst = 0;
        model_reset();
        beat(8'd4, 1);
        chk("rm_valid_after", 32'(out_valid), 1);
        chk("rm_sum", 32'(out_sum), 4);
        chk("rm_count", 32'(out_count), 1);
        idle();

        // Random traffic against the reference model
        drained = 0;
        cycles = 0;
        while (drained < 1000 && cycles < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_prod   = 8'($urandom_range(0, 15) * $urandom_range(0, 15));
            in_last   = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            chk("rnd_valid", 32'(out_valid), 32'(e_valid));
            chk("rnd_in_ready", 32'(in_ready), 32'(!e_valid || out_ready));
            if (e_valid) begin
                chk("rnd_sum", 32'(out_sum), 32'(e_sum));
                chk("rnd_count", 32'(out_count), 32'(e_cnt));
                chk("rnd_forced", 32'(out_forced), 32'(e_forced));
                if (out_ready) drained++;
            end
            tick();
            cycles++;
        end
        chk("rnd_bursts_done", 32'(drained >= 1000), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
